// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: datapath sizes, instruction
// field positions, the opcode set and small helpers describing which source
// registers each opcode reads.
package id_stage_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int OP_W     = 6;
    localparam int IMM_W    = 16;

    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;

    typedef enum logic [OP_W-1:0] {
        OP_ALU  = 6'd0,
        OP_ALUI = 6'd1,
        OP_LD   = 6'd2,
        OP_ST   = 6'd3,
        OP_BEQ  = 6'd4,
        OP_JMP  = 6'd5
    } opcode_e;

    // Anything outside the opcode set decodes as a NOP.
    function automatic logic isKnownOp(input logic [OP_W-1:0] op);
        return op inside {OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BEQ, OP_JMP};
    endfunction

    // JMP reads no register; every other real opcode reads rs1.
    function automatic logic usesRs1(input logic [OP_W-1:0] op);
        return op inside {OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BEQ};
    endfunction

    function automatic logic usesRs2(input logic [OP_W-1:0] op);
        return op inside {OP_ALU, OP_ST, OP_BEQ};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF <-> ID link. IF (master) presents PC/IR; ID (slave) answers with the
// stall and redirect controls.
//   PC, IR                     : IF -> ID, instruction being decoded
//   IsStall, IsBranch, BranchAddr : ID -> IF, hold / redirect controls
interface id_stage_if
    import id_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
);
    logic [WIDTH-3:0] PC;
    logic [WIDTH-1:0] IR;
    logic             IsStall;
    logic             IsBranch;
    logic [WIDTH-3:0] BranchAddr;

    modport master (output PC, IR, input IsStall, IsBranch, BranchAddr);
    modport slave  (input PC, IR, output IsStall, IsBranch, BranchAddr);
endinterface

// File: rtl/id_stage_regfile.sv
// Architectural register file: two combinational read ports, one write port.
//   raddr1_i/raddr2_i -> rdata1_o/rdata2_o : reads, r0 always returns zero
//   we_i, waddr_i, wdata_i                 : write port, commits at posedge
// A read of the register being written this cycle returns the write data so
// the decoder never sees a stale value one cycle behind WB.
module id_regfile
    import id_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREG  = NUM_REGS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] raddr1_i,
    input  logic [REG_W-1:0] raddr2_i,
    output logic [WIDTH-1:0] rdata1_o,
    output logic [WIDTH-1:0] rdata2_o,
    input  logic             we_i,
    input  logic [REG_W-1:0] waddr_i,
    input  logic [WIDTH-1:0] wdata_i
);

    logic [WIDTH-1:0] regs_q [NREG];

    // Writes to r0 are dropped so r0 stays zero in storage as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0)                   ? '0      :
                      (we_i && waddr_i == raddr1_i)      ? wdata_i :
                                                           regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                   ? '0      :
                      (we_i && waddr_i == raddr2_i)      ? wdata_i :
                                                           regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// Decode stage between IF and EX. Decodes IR/PC from IF, reads the register
// file, resolves BEQ/JMP and registers the ID/EX bundle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ifBus (slave)     : PC/IR in; IsStall, IsBranch, BranchAddr back to IF
//   wb_en/wb_rd/wb_data : register file write port from WB
//   mem_*             : MEM-stage ALU forwarding and pending-load status
//   ex_*              : registered ID/EX bundle (ex_valid=0 marks a bubble)
module id_stage
    import id_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NREG  = NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    id_stage_if.slave         ifBus,
    input  logic              wb_en,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [WIDTH-1:0]  wb_data,
    input  logic              mem_fwd_en,
    input  logic              mem_ld_pend,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic [WIDTH-1:0]  mem_fwd_data,
    output logic              ex_valid,
    output logic [WIDTH-3:0]  ex_pc,
    output logic [OP_W-1:0]   ex_op,
    output logic [REG_W-1:0]  ex_rd,
    output logic [WIDTH-1:0]  ex_a,
    output logic [WIDTH-1:0]  ex_b,
    output logic [WIDTH-1:0]  ex_imm
);

    localparam logic [WIDTH-3:0] PC_STEP = 4;

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0] imm16;
    logic [WIDTH-1:0] immExt, rs1Val, rs2Val, cmpA, cmpB;
    logic             instrValid, exWrites, loadUse, branchDep, stall, taken, branch;

    logic             started_q, started_d;
    logic             squash_q, squash_d;
    logic             exValid_q, exValid_d;
    logic [WIDTH-3:0] exPc_q, exPc_d;
    logic [OP_W-1:0]  exOp_q, exOp_d;
    logic [REG_W-1:0] exRd_q, exRd_d;
    logic [WIDTH-1:0] exA_q, exA_d, exB_q, exB_d, exImm_q, exImm_d;

    assign op     = ifBus.IR[OP_LSB +: OP_W];
    assign rd     = ifBus.IR[RD_LSB +: REG_W];
    assign rs1    = ifBus.IR[RS1_LSB +: REG_W];
    assign rs2    = ifBus.IR[RS2_LSB +: REG_W];
    assign imm16  = ifBus.IR[IMM_W-1:0];
    assign immExt = {{(WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};

    id_regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1Val),
        .rdata2_o (rs2Val),
        .we_i     (wb_en),
        .waddr_i  (wb_rd),
        .wdata_i  (wb_data)
    );

    // The branch comparator is the only consumer of MEM forwarding; EX
    // operands come straight from the register file.
    assign cmpA = (mem_fwd_en && mem_rd == rs1 && rs1 != '0) ? mem_fwd_data : rs1Val;
    assign cmpB = (mem_fwd_en && mem_rd == rs2 && rs2 != '0) ? mem_fwd_data : rs2Val;

    assign instrValid = started_q && !squash_q && isKnownOp(op);

    // A load in EX cannot feed anything yet. BEQ resolves here, so it must
    // also wait for any EX writer and for a load still pending in MEM.
    assign exWrites  = exValid_q && exRd_q != '0;
    assign loadUse   = exWrites && exOp_q == OP_LD &&
                       ((usesRs1(op) && rs1 == exRd_q) || (usesRs2(op) && rs2 == exRd_q));
    assign branchDep = (op == OP_BEQ) &&
                       ((exWrites && (rs1 == exRd_q || rs2 == exRd_q)) ||
                        (mem_ld_pend && ((rs1 == mem_rd && rs1 != '0) ||
                                         (rs2 == mem_rd && rs2 != '0))));
    assign stall  = instrValid && (loadUse || branchDep);
    assign taken  = (op == OP_JMP) || (op == OP_BEQ && cmpA == cmpB);
    assign branch = instrValid && taken && !stall;

    assign ifBus.IsStall    = stall;
    assign ifBus.IsBranch   = branch;
    assign ifBus.BranchAddr = ifBus.PC + PC_STEP + {immExt[WIDTH-5:0], 2'b00};

    // Next ID/EX bundle: only a live, unstalled instruction issues; bubbles
    // keep the previous payload. The slot after a taken branch is squashed.
    always_comb begin
        started_d = 1'b1;
        squash_d  = branch;
        exValid_d = instrValid && !stall;
        exPc_d    = exPc_q;
        exOp_d    = exOp_q;
        exRd_d    = exRd_q;
        exA_d     = exA_q;
        exB_d     = exB_q;
        exImm_d   = exImm_q;
        if (exValid_d) begin
            exPc_d  = ifBus.PC;
            exOp_d  = op;
            exRd_d  = (op == OP_ST || op == OP_BEQ) ? '0 : rd;
            exA_d   = rs1Val;
            exB_d   = rs2Val;
            exImm_d = immExt;
        end
    end

    // Pipeline state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            squash_q  <= 1'b0;
            exValid_q <= 1'b0;
            exPc_q    <= '0;
            exOp_q    <= '0;
            exRd_q    <= '0;
            exA_q     <= '0;
            exB_q     <= '0;
            exImm_q   <= '0;
        end else begin
            started_q <= started_d;
            squash_q  <= squash_d;
            exValid_q <= exValid_d;
            exPc_q    <= exPc_d;
            exOp_q    <= exOp_d;
            exRd_q    <= exRd_d;
            exA_q     <= exA_d;
            exB_q     <= exB_d;
            exImm_q   <= exImm_d;
        end
    end

    assign ex_valid = exValid_q;
    assign ex_pc    = exPc_q;
    assign ex_op    = exOp_q;
    assign ex_rd    = exRd_q;
    assign ex_a     = exA_q;
    assign ex_b     = exB_q;
    assign ex_imm   = exImm_q;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_id_stage;
    import id_stage_pkg::*;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wb_en, mem_fwd_en, mem_ld_pend;
    logic [4:0]      wb_rd, mem_rd;
    logic [W-1:0]    wb_data, mem_fwd_data;
    logic            ex_valid;
    logic [W-3:0]    ex_pc;
    logic [5:0]      ex_op;
    logic [4:0]      ex_rd;
    logic [W-1:0]    ex_a, ex_b, ex_imm;

    id_stage_if #(.WIDTH(W)) ifBus ();

    id_stage #(.WIDTH(W), .NREG(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifBus        (ifBus),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .mem_fwd_en   (mem_fwd_en),
        .mem_ld_pend  (mem_ld_pend),
        .mem_rd       (mem_rd),
        .mem_fwd_data (mem_fwd_data),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_op        (ex_op),
        .ex_rd        (ex_rd),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_imm       (ex_imm)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state
    logic [31:0] mRegs [32];
    bit          mStarted, mSquash, mExValid;
    logic [29:0] mExPc;
    logic [5:0]  mExOp;
    logic [4:0]  mExRd;
    logic [31:0] mExA, mExB, mExImm;
    // Model predictions for the current inputs
    bit          eStall, eBranch, eIssue;
    logic [29:0] eTarget;
    logic [5:0]  eOp;
    logic [4:0]  eRd;
    logic [31:0] eA, eB, eImm;
    // DUT combinational outputs sampled mid-cycle
    logic        sStall, sBranch;
    logic [29:0] sAddr;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mkI(input int op, input int rd, input int rs1, input int imm);
        return {6'(op), 5'(rd), 5'(rs1), 16'(imm)};
    endfunction

    function automatic logic [31:0] mkR(input int op, input int rd, input int rs1, input int rs2);
        return mkI(op, rd, rs1, rs2 << 11);
    endfunction

    function automatic logic [31:0] regValue(input int r);
        if (r == 0) return 32'd0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return mRegs[r];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
        mStarted = 0; mSquash = 0; mExValid = 0;
        mExPc = '0; mExOp = '0; mExRd = '0; mExA = '0; mExB = '0; mExImm = '0;
    endtask

    // What ID must do with the instruction presented right now.
    task automatic modelComb();
        int  op, rd, rs1, rs2, simm;
        bit  valid, readsA, readsB, hit1, hit2, ldp1, ldp2, loadUse, beqWait;
        logic [31:0] a, b;
        op   = int'(ifBus.IR[31:26]);
        rd   = int'(ifBus.IR[25:21]);
        rs1  = int'(ifBus.IR[20:16]);
        rs2  = int'(ifBus.IR[15:11]);
        simm = int'($signed(ifBus.IR[15:0]));
        valid  = mStarted && !mSquash && (op < 6);
        readsA = (op <= 4);
        readsB = (op == 0 || op == 3 || op == 4);
        hit1 = rs1 != 0 && mExValid && int'(mExRd) == rs1;
        hit2 = rs2 != 0 && mExValid && int'(mExRd) == rs2;
        ldp1 = mem_ld_pend && rs1 != 0 && int'(mem_rd) == rs1;
        ldp2 = mem_ld_pend && rs2 != 0 && int'(mem_rd) == rs2;
        loadUse = (mExOp == 6'd2) && ((readsA && hit1) || (readsB && hit2));
        beqWait = (op == 4) && (hit1 || hit2 || ldp1 || ldp2);
        eStall  = valid && (loadUse || beqWait);
        a = (mem_fwd_en && rs1 != 0 && int'(mem_rd) == rs1) ? mem_fwd_data : regValue(rs1);
        b = (mem_fwd_en && rs2 != 0 && int'(mem_rd) == rs2) ? mem_fwd_data : regValue(rs2);
        eBranch = valid && !eStall && (op == 5 || (op == 4 && a == b));
        eTarget = ifBus.PC + 30'd4 + 30'(4 * simm);
        eIssue  = valid && !eStall;
        eOp  = 6'(op);
        eRd  = (op == 3 || op == 4) ? 5'd0 : 5'(rd);
        eA   = regValue(rs1);
        eB   = regValue(rs2);
        eImm = 32'(simm);
    endtask

    task automatic modelClock();
        modelComb();
        mExValid = eIssue;
        if (eIssue) begin
            mExPc = ifBus.PC; mExOp = eOp; mExRd = eRd;
            mExA = eA; mExB = eB; mExImm = eImm;
        end
        mSquash  = eBranch;
        mStarted = 1;
        if (wb_en && wb_rd != 0) mRegs[wb_rd] = wb_data;
    endtask

    task automatic checkOutput();
        sStall  = ifBus.IsStall;
        sBranch = ifBus.IsBranch;
        sAddr   = ifBus.BranchAddr;
        checkVal("IsStall", sStall, eStall);
        checkVal("IsBranch", sBranch, eBranch);
        checkVal("BranchAddr", sAddr, eTarget);
    endtask

    task automatic checkEx();
        checkVal("ex_valid", ex_valid, mExValid);
        if (mExValid) begin
            checkVal("ex_pc", ex_pc, mExPc);
            checkVal("ex_op", ex_op, mExOp);
            checkVal("ex_rd", ex_rd, mExRd);
            checkVal("ex_a", ex_a, mExA);
            checkVal("ex_b", ex_b, mExB);
            checkVal("ex_imm", ex_imm, mExImm);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, " ex_valid"}, ex_valid, 0);
        checkVal({tag, " ex_pc"}, ex_pc, 0);
        checkVal({tag, " ex_op"}, ex_op, 0);
        checkVal({tag, " ex_rd"}, ex_rd, 0);
        checkVal({tag, " ex_a"}, ex_a, 0);
        checkVal({tag, " ex_b"}, ex_b, 0);
        checkVal({tag, " ex_imm"}, ex_imm, 0);
        checkVal({tag, " IsStall"}, ifBus.IsStall, 0);
        checkVal({tag, " IsBranch"}, ifBus.IsBranch, 0);
    endtask

    // One clock of IF traffic: drive at negedge, check decode mid-cycle,
    // optionally pulse async reset, then check the registered bundle.
    task automatic applyStimulus(input logic [29:0] pc, input logic [31:0] ir,
                                 input bit we, input int wrd, input logic [31:0] wd,
                                 input bit fe, input bit lp, input int mrd,
                                 input logic [31:0] fd, input bit doReset);
        @(negedge clk);
        ifBus.PC = pc; ifBus.IR = ir;
        wb_en = we; wb_rd = 5'(wrd); wb_data = wd;
        mem_fwd_en = fe; mem_ld_pend = lp; mem_rd = 5'(mrd); mem_fwd_data = fd;
        #1;
        modelComb();
        checkOutput();
        if (doReset) begin
            #1 rst_n = 1'b0;
            #1 checkAllZero("async reset");
            modelReset();
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        modelClock();
        #1 checkEx();
    endtask

    logic [31:0] nop;
    logic [29:0] pc;
    logic [31:0] ir;
    bit          holdIr;

    initial begin
        nop = mkI(63, 0, 0, 0);
        ifBus.PC = '0; ifBus.IR = nop;
        wb_en = 0; wb_rd = 0; wb_data = 0;
        mem_fwd_en = 0; mem_ld_pend = 0; mem_rd = 0; mem_fwd_data = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1 checkAllZero("reset");
        #1 rst_n = 1'b1;

        // First instruction after reset is not trusted, the repeat issues.
        applyStimulus(30'h0, mkR(0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("first cycle ex_valid", ex_valid, 0);
        applyStimulus(30'h0, mkR(0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("second cycle ex_valid", ex_valid, 1);
        checkVal("second cycle ex_rd", ex_rd, 1);

        // Write-through from WB and r0 immunity.
        applyStimulus(30'h4, mkR(0, 6, 5, 0), 1, 5, 32'hDEAD, 0, 0, 0, 0, 0);
        checkVal("wb write-through ex_a", ex_a, 32'hDEAD);
        applyStimulus(30'h8, mkR(0, 6, 0, 0), 1, 0, 32'h1234, 0, 0, 0, 0, 0);
        checkVal("r0 during write ex_a", ex_a, 0);
        applyStimulus(30'hC, mkR(0, 6, 0, 0), 1, 4, 32'h44, 0, 0, 0, 0, 0);
        checkVal("r0 after write ex_a", ex_a, 0);

        // Load-use: one stall cycle, then the consumer issues.
        applyStimulus(30'h10, mkI(2, 4, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("LD ex_op", ex_op, 2);
        applyStimulus(30'h14, mkR(0, 7, 4, 1), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("load-use IsStall", sStall, 1);
        checkVal("load-use bubble", ex_valid, 0);
        applyStimulus(30'h14, mkR(0, 7, 4, 1), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("after stall IsStall", sStall, 0);
        checkVal("after stall ex_valid", ex_valid, 1);
        checkVal("after stall ex_a", ex_a, 32'h44);

        // Taken BEQ; rs2 shares imm bits, so r0,r0 keeps imm = 3.
        applyStimulus(30'h10, mkI(4, 0, 0, 3), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("BEQ IsBranch", sBranch, 1);
        checkVal("BEQ BranchAddr", sAddr, 30'h20);
        checkVal("BEQ ex_rd", ex_rd, 0);
        applyStimulus(30'h14, mkR(0, 2, 1, 1), 1, 2, 32'd5, 0, 0, 0, 0, 0);
        checkVal("slot IsBranch", sBranch, 0);
        checkVal("slot squashed", ex_valid, 0);
        applyStimulus(30'h20, nop, 1, 3, 32'd9, 0, 0, 0, 0, 0);
        checkVal("NOP ex_valid", ex_valid, 0);

        // BEQ r2(5) vs r3(9) is equal only through MEM forwarding of r2=9.
        applyStimulus(30'h40, mkR(4, 0, 2, 3), 0, 0, 0, 1, 0, 2, 32'd9, 0);
        checkVal("fwd BEQ IsBranch", sBranch, 1);
        checkVal("fwd BEQ BranchAddr", sAddr, 30'h6044);
        applyStimulus(30'h44, nop, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(30'h6044, mkR(4, 0, 2, 3), 0, 0, 0, 0, 1, 3, 0, 0);
        checkVal("ld-pend IsStall", sStall, 1);
        checkVal("ld-pend IsBranch", sBranch, 0);
        // Reset lands while the stall is still held.
        applyStimulus(30'h6044, mkR(4, 0, 2, 3), 0, 0, 0, 0, 1, 3, 0, 1);
        checkVal("post-reset first ex_valid", ex_valid, 0);
        applyStimulus(30'h0, mkR(0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("post-reset issue ex_valid", ex_valid, 1);
        checkVal("post-reset issue ex_rd", ex_rd, 1);

        // Randomized traffic, with the bench acting as IF.
        pc = 30'h100;
        holdIr = 0;
        ir = nop;
        for (int n = 0; n < 800; n++) begin
            if (!holdIr) begin
                int op, rs1, rs2;
                op  = $urandom_range(0, 7);
                rs1 = $urandom_range(0, 7);
                rs2 = ($urandom_range(0, 9) < 3) ? rs1 : $urandom_range(0, 7);
                ir = {6'(op), 5'($urandom_range(0, 7)), 5'(rs1), 5'(rs2), 11'($urandom)};
                if (op == 6) ir[31:26] = 6'($urandom_range(6, 63));
            end
            applyStimulus(pc, ir,
                          $urandom_range(0, 1), $urandom_range(0, 7), 32'($urandom_range(0, 3)),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7), 32'($urandom_range(0, 3)),
                          $urandom_range(0, 99) == 0);
            holdIr = eStall;
            if (eBranch) pc = eTarget;
            else if (!eStall) pc = pc + 30'd4;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
